id_ex_reg: RTL and testbench

ID/EX pipeline register for the five-stage MIPS pipeline. It captures decoded operands, the sign-extended immediate, register specifiers and control bits from the decode stage, and presents them to the execute stage. Its `ex_alu_src`, `ex_read_rt` and `ex_sign_ext` outputs drive the EX operand-B mux directly. It also supports stall and flush, and contains the load-use hazard detector that requests the stall.

---
 rtl/id_ex_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_reg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register for the five-stage MIPS pipeline, with the
// load-use hazard detector that asks the decode stage to stall.
//
// Parameters
//   DATA_W  datapath width (PC+4, register read data, extended immediate)
//   REG_W   register-specifier width
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall, flush          hold contents / load a bubble (flush wins)
//   id_*                  decode-stage fields to capture
//   ex_*                  registered copies presented to execute, + ex_valid
//   load_use_haz          combinational stall request to decode
//   perf_bubbles/stalls   event counters, only with IDEX_PERF_EN defined
//
// Build option
//   IDEX_PERF_EN  adds the perf_bubbles / perf_stalls counters and ports.
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_read_rs,
    input  logic [DATA_W-1:0] id_read_rt,
    input  logic [DATA_W-1:0] id_sign_ext,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_reg_write,
    input  logic              id_branch,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_read_rs,
    output logic [DATA_W-1:0] ex_read_rt,
    output logic [DATA_W-1:0] ex_sign_ext,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              load_use_haz
`ifdef IDEX_PERF_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_stalls
`endif
);

    // Reset and flush both produce an all-zero register, so they share a
    // branch; stall simply leaves every register untouched.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid      <= 1'b0;
            ex_pc4        <= '0;
            ex_read_rs    <= '0;
            ex_read_rt    <= '0;
            ex_sign_ext   <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc4        <= id_pc4;
            ex_read_rs    <= id_read_rs;
            ex_read_rt    <= id_read_rt;
            ex_sign_ext   <= id_sign_ext;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            // An invalid slot still carries its data, but must not carry
            // any control that could cause a side effect downstream.
            ex_alu_op     <= id_valid ? id_alu_op : 4'd0;
            ex_alu_src    <= id_valid & id_alu_src;
            ex_reg_dst    <= id_valid & id_reg_dst;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_branch     <= id_valid & id_branch;
        end
    end

    // A load in EX whose destination is a source of the instruction in ID.
    // Register 0 is never a real dependency.
    logic rtNonZero;
    logic srcMatch;

    assign rtNonZero    = (ex_rt != '0);
    assign srcMatch     = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign load_use_haz = ex_valid & ex_mem_read & rtNonZero & srcMatch & id_valid;

`ifdef IDEX_PERF_EN
    // Stall only counts when it actually holds, i.e. no flush this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubbles <= '0;
            perf_stalls  <= '0;
        end else if (flush) begin
            perf_bubbles <= perf_bubbles + 32'd1;
        end else if (stall) begin
            perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, stall, flush, idValid;
    logic [DW-1:0] idPc4, idReadRs, idReadRt, idSignExt;
    logic [RW-1:0] idRs, idRt, idRd;
    logic [3:0]    idAluOp;
    logic          idAluSrc, idRegDst, idMemRead, idMemWrite, idMemToReg, idRegWrite, idBranch;

    logic          exValid;
    logic [DW-1:0] exPc4, exReadRs, exReadRt, exSignExt;
    logic [RW-1:0] exRs, exRt, exRd;
    logic [3:0]    exAluOp;
    logic          exAluSrc, exRegDst, exMemRead, exMemWrite, exMemToReg, exRegWrite, exBranch;
    logic          loadUseHaz;
`ifdef IDEX_PERF_EN
    logic [31:0]   perfBubbles, perfStalls;
`endif

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(idValid),
        .id_pc4(idPc4), .id_read_rs(idReadRs), .id_read_rt(idReadRt), .id_sign_ext(idSignExt),
        .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_alu_op(idAluOp),
        .id_alu_src(idAluSrc), .id_reg_dst(idRegDst), .id_mem_read(idMemRead),
        .id_mem_write(idMemWrite), .id_mem_to_reg(idMemToReg), .id_reg_write(idRegWrite),
        .id_branch(idBranch),
        .ex_valid(exValid), .ex_pc4(exPc4), .ex_read_rs(exReadRs), .ex_read_rt(exReadRt),
        .ex_sign_ext(exSignExt), .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd), .ex_alu_op(exAluOp),
        .ex_alu_src(exAluSrc), .ex_reg_dst(exRegDst), .ex_mem_read(exMemRead),
        .ex_mem_write(exMemWrite), .ex_mem_to_reg(exMemToReg), .ex_reg_write(exRegWrite),
        .ex_branch(exBranch), .load_use_haz(loadUseHaz)
`ifdef IDEX_PERF_EN
        ,
        .perf_bubbles(perfBubbles), .perf_stalls(perfStalls)
`endif
    );

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passCnt++;
    endtask

    // Model: the slot in EX is one record of what the instruction looks like.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc4, readRs, readRt, signExt;
        logic [RW-1:0] rs, rt, rd;
        logic [3:0]    aluOp;
        logic          aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch;
    } slot_t;

    slot_t       mSlot;
    logic        armed = 1'b0;
    logic [31:0] mBubbles, mStalls;

    function automatic slot_t decodeSlot();
        slot_t s;
        s = '{valid: idValid, pc4: idPc4, readRs: idReadRs, readRt: idReadRt,
              signExt: idSignExt, rs: idRs, rt: idRt, rd: idRd, default: '0};
        if (idValid) begin
            s.aluOp    = idAluOp;    s.aluSrc   = idAluSrc;   s.regDst = idRegDst;
            s.memRead  = idMemRead;  s.memWrite = idMemWrite; s.memToReg = idMemToReg;
            s.regWrite = idRegWrite; s.branch   = idBranch;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mSlot    <= '0;
            mBubbles <= '0;
            mStalls  <= '0;
            armed    <= 1'b1;
        end else if (flush) begin
            mSlot    <= '0;
            mBubbles <= mBubbles + 1;
        end else if (stall) begin
            mStalls  <= mStalls + 1;
        end else begin
            mSlot    <= decodeSlot();
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid",    exValid,    mSlot.valid);
            chk("pc4",      exPc4,      mSlot.pc4);
            chk("readRs",   exReadRs,   mSlot.readRs);
            chk("readRt",   exReadRt,   mSlot.readRt);
            chk("signExt",  exSignExt,  mSlot.signExt);
            chk("rs",       exRs,       mSlot.rs);
            chk("rt",       exRt,       mSlot.rt);
            chk("rd",       exRd,       mSlot.rd);
            chk("aluOp",    exAluOp,    mSlot.aluOp);
            chk("aluSrc",   exAluSrc,   mSlot.aluSrc);
            chk("regDst",   exRegDst,   mSlot.regDst);
            chk("memRead",  exMemRead,  mSlot.memRead);
            chk("memWrite", exMemWrite, mSlot.memWrite);
            chk("memToReg", exMemToReg, mSlot.memToReg);
            chk("regWrite", exRegWrite, mSlot.regWrite);
            chk("branch",   exBranch,   mSlot.branch);
            chk("haz", loadUseHaz,
                mSlot.valid && mSlot.memRead && mSlot.rt != 0 && idValid &&
                (mSlot.rt == idRs || mSlot.rt == idRt));
`ifdef IDEX_PERF_EN
            chk("perfBubbles", perfBubbles, mBubbles);
            chk("perfStalls",  perfStalls,  mStalls);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idleInputs();
        stall = 0; flush = 0; idValid = 0;
        idPc4 = 0; idReadRs = 0; idReadRt = 0; idSignExt = 0;
        idRs = 0; idRt = 0; idRd = 0; idAluOp = 0;
        idAluSrc = 0; idRegDst = 0; idMemRead = 0; idMemWrite = 0;
        idMemToReg = 0; idRegWrite = 0; idBranch = 0;
    endtask

    initial begin
        reset = 1;
        idleInputs();
        tick(); tick();
        chk("rst.valid",   exValid,    0);
        chk("rst.signExt", exSignExt,  0);
        chk("rst.aluOp",   exAluOp,    0);
        chk("rst.haz",     loadUseHaz, 0);

        // Reset, then capture
        reset = 0;
        idValid = 1; idReadRt = 32'h0000_0005; idSignExt = 32'hFFFF_FFFC; idAluSrc = 1;
        tick();
        chk("cap.signExt", exSignExt, 32'hFFFF_FFFC);
        chk("cap.aluSrc",  exAluSrc,  1);
        chk("cap.valid",   exValid,   1);
        chk("cap.readRt",  exReadRt,  32'h0000_0005);

        // Stall hold for 3 cycles
        idReadRs = 32'h1111_1111;
        tick();
        stall = 1; idReadRs = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.hold", exReadRs, 32'h1111_1111);
        end
        stall = 0;
        tick();
        chk("stall.release", exReadRs, 32'h2222_2222);

        // Flush together with stall
        idRegWrite = 1; idMemWrite = 1; idReadRt = 32'hABCD_0123;
        tick();
        chk("preflush.regWrite", exRegWrite, 1);
        flush = 1; stall = 1;
        tick();
        chk("flush.valid",    exValid,    0);
        chk("flush.regWrite", exRegWrite, 0);
        chk("flush.memWrite", exMemWrite, 0);
        chk("flush.readRt",   exReadRt,   0);
        flush = 0; stall = 0;

        // Load-use: load with rt=8 sits in EX; decode holds with stall
        idRegWrite = 1; idMemWrite = 0; idMemRead = 1; idRt = 8; idRs = 1;
        tick();
        chk("load.rt", exRt, 8);
        stall = 1; idMemRead = 0; idRegWrite = 0;
        idRs = 8; idRt = 3;
        #1 chk("haz.rsMatch", loadUseHaz, 1);
        tick();
        idRs = 9; idRt = 9;
        #1 chk("haz.noMatch", loadUseHaz, 0);
        tick();
        idRs = 3; idRt = 8;
        #1 chk("haz.rtMatch", loadUseHaz, 1);
        tick();
        idValid = 0;
        #1 chk("haz.idInvalid", loadUseHaz, 0);
        tick();
        idValid = 1; stall = 0; flush = 1;
        tick();
        chk("haz.afterBubble", loadUseHaz, 0);
        flush = 0;
        idMemRead = 1; idRt = 0; idRs = 0;
        tick();
        stall = 1; idMemRead = 0;
        #1 chk("haz.rtZero", loadUseHaz, 0);
        tick();
        stall = 0;

        // Invalid capture keeps data, drops control
        idValid = 0; idRegWrite = 1; idMemWrite = 1; idReadRs = 32'h5A5A_5A5A;
        tick();
        chk("inv.regWrite", exRegWrite, 0);
        chk("inv.memWrite", exMemWrite, 0);
        chk("inv.valid",    exValid,    0);
        chk("inv.readRs",   exReadRs,   32'h5A5A_5A5A);

        // Reset mid-stream beats stall and flush
        idValid = 1; idPc4 = 32'h0040_0010;
        tick();
        reset = 1; stall = 1; flush = 1;
        tick();
        chk("midRst.valid", exValid, 0);
        chk("midRst.pc4",   exPc4,   0);
        reset = 0; stall = 0; flush = 0;

        // Directed vectors through the model
        for (int i = 0; i < 8; i++) begin
            idValid    = (i % 3) != 2;
            idPc4      = 32'h0040_0000 + 32'(i * 4);
            idReadRs   = 32'hA000_0000 | 32'(i);
            idReadRt   = 32'h0B00_0000 | 32'(i << 4);
            idSignExt  = (i % 2) ? 32'hFFFF_8000 : 32'h0000_7FFF;
            idRs       = 5'(i + 1);
            idRt       = 5'(i + 2);
            idRd       = 5'(31 - i);
            idAluOp    = 4'(i);
            idAluSrc   = i[0];
            idRegDst   = i[1];
            idMemRead  = i[2];
            idMemWrite = ~i[0];
            idMemToReg = i[2];
            idRegWrite = ~i[1];
            idBranch   = (i == 5);
            stall      = (i == 4);
            flush      = (i == 6);
            tick();
        end
        stall = 0; flush = 0;
        tick();

`ifdef IDEX_PERF_EN
        reset = 1;
        tick();
        reset = 0;
        flush = 1;
        tick(); tick();
        flush = 0; stall = 1;
        tick(); tick(); tick();
        stall = 0;
        tick();
        chk("perf.bubbles", perfBubbles, 2);
        chk("perf.stalls",  perfStalls,  3);
        reset = 1;
        tick();
        chk("perf.rstBubbles", perfBubbles, 0);
        chk("perf.rstStalls",  perfStalls,  0);
        reset = 0;
        tick();
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
